game_minute_timer: RTL and testbench
====================================

Name: game_minute_timer

Overview:
Upstream time base for the game-state FSM. Divides Clk into game minutes and drives the FSM's 8-bit `minutes` input, which feeds the quiz, deadline and win/lose logic. Also drives a BCD copy of the count to the seven-segment display path and a one-cycle minute tick. Counting is gated by the FSM: cleared while in INI, frozen in WIN/LOSE.

Parameters:
TICKS_PER_MIN, 100000000, Clk cycles per game minute in normal mode (1 s at 100 MHz); must be >= 2.
FAST_DIV, 16, divisor applied to TICKS_PER_MIN in fast-forward mode; must be >= 1, and TICKS_PER_MIN/FAST_DIV must be >= 1.
MAX_MIN, 255, saturation value of `minutes`; must be <= 255.

Ports:
Clk  input  1  system clock
Reset  input  1  asynchronous, active-high reset
clear  input  1  synchronous clear, driven from q_INI
run  input  1  count enable, high in all states except INI/WIN/LOSE
fast  input  1  fast-forward select (demo switch)
minutes  output  8  elapsed game minutes, registered
minutes_bcd  output  12  BCD of `minutes`: [11:8] hundreds, [7:4] tens, [3:0] ones; registered
min_tick  output  1  one-cycle pulse in the cycle `minutes` increments
saturated  output  1  high while minutes == MAX_MIN

Behaviour:
- Reset (async, active-high): prescaler, minutes, minutes_bcd, min_tick and saturated all go to 0.
- Prescaler `pcnt`: width $clog2(TICKS_PER_MIN).
- Terminal value `term`: `fast ? TICKS_PER_MIN/FAST_DIV - 1 : TICKS_PER_MIN - 1` (integer division).
- Priority order each rising Clk edge:
  1. clear: pcnt, minutes and minutes_bcd go to 0; min_tick goes to 0. This applies whatever the state of run/fast.
  2. run low: all state holds; min_tick goes to 0.
  3. run high, pcnt < term: pcnt increments; min_tick goes to 0.
  4. run high, pcnt >= term (rollover):
     - pcnt goes to 0.
     - If minutes < MAX_MIN: minutes increments by 1, minutes_bcd increments, min_tick goes to 1 for exactly this cycle.
     - Else: minutes holds and min_tick stays 0.
- The `>=` compare is required. If fast rises while pcnt is already above the new term, rollover happens on the next edge; there is no long wrap.
- BCD increment runs in parallel, not by binary conversion:
  - ones 9 -> 0 with carry into tens;
  - tens 9 -> 0 with carry into hundreds.
  - minutes_bcd must always equal the decimal value of minutes in the same cycle.
- saturated: registered, updated together with minutes, equal to (next minutes == MAX_MIN). Once saturated, further rollovers still reset pcnt but produce no tick and no count change. Only clear or Reset leaves saturation.
- Latency:
  - minutes, minutes_bcd and min_tick change on the same edge as the rollover.
  - run deassert takes effect on the next edge; no partial minute is lost, because pcnt is retained.
- Clear while run is high: the cleared state is taken, and counting resumes from pcnt = 0 on the first edge with clear low.
- Reset mid-minute: the partial count is discarded.
- No combinational path from any input to any output.
- Target size: about 150 lines.

Test Plan (TICKS_PER_MIN=10, FAST_DIV=5, MAX_MIN=255 unless noted):
1. Reset, then run=1, fast=0 for 35 cycles -> minutes=3, minutes_bcd=12'h003, min_tick high exactly on cycles 10, 20 and 30 after run, each for one cycle.
2. run=1 for 4 cycles, run=0 for 20 cycles, run=1 for 6 more -> minutes steps 0 -> 1 only on the 10th enabled cycle; no tick while run=0.
3. Run to pcnt=7 in normal mode, then set fast=1 -> rollover on the next edge (7 >= 1). After that, one tick every 2 cycles.
4. Count to 99 -> next tick gives minutes=100 and minutes_bcd=12'h100. Continue to 255 -> saturated=1 and minutes_bcd=12'h255. A further 50 cycles give no tick and no change.
5. Assert clear for 1 cycle at minutes=37 with run=1 -> minutes=0, bcd=0, saturated=0, min_tick=0. The next tick comes exactly 10 cycles after clear falls.
6. Assert async Reset mid-minute (pcnt=5, minutes=2), asynchronous to Clk -> all outputs go to 0 immediately. After Reset falls with run=1, the first tick comes 10 cycles later.

Source files
------------

// File: rtl/game_minute_timer.sv
// Game-minute time base: divides Clk into game minutes and keeps a binary count,
// a parallel BCD copy, a one-cycle minute tick and a saturation flag.
module game_minute_timer #(
    parameter int TICKS_PER_MIN = 100000000,
    parameter int FAST_DIV      = 16,
    parameter int MAX_MIN       = 255
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        clear,
    input  logic        run,
    input  logic        fast,
    output logic [7:0]  minutes,
    output logic [11:0] minutes_bcd,
    output logic        min_tick,
    output logic        saturated
);

    localparam int PW = $clog2(TICKS_PER_MIN);
    localparam logic [PW-1:0] TERM_NORM = PW'(TICKS_PER_MIN - 1);
    localparam logic [PW-1:0] TERM_FAST = PW'(TICKS_PER_MIN / FAST_DIV - 1);
    localparam logic [7:0]    MAX_M     = 8'(MAX_MIN);

    logic [PW-1:0] pcnt, pcnt_nxt, term;
    logic [7:0]    min_nxt;
    logic [11:0]   bcd_nxt, bcd_inc;
    logic          tick_nxt;

    assign term = fast ? TERM_FAST : TERM_NORM;

    // Decimal increment done digit-wise so the BCD copy tracks minutes every cycle.
    always_comb begin
        bcd_inc = minutes_bcd;
        if (minutes_bcd[3:0] == 4'd9) begin
            bcd_inc[3:0] = 4'd0;
            if (minutes_bcd[7:4] == 4'd9) begin
                bcd_inc[7:4]  = 4'd0;
                bcd_inc[11:8] = minutes_bcd[11:8] + 4'd1;
            end else begin
                bcd_inc[7:4] = minutes_bcd[7:4] + 4'd1;
            end
        end else begin
            bcd_inc[3:0] = minutes_bcd[3:0] + 4'd1;
        end
    end

    // The >= compare makes a fast-mode switch with pcnt above term roll over at once.
    always_comb begin
        pcnt_nxt = pcnt;
        min_nxt  = minutes;
        bcd_nxt  = minutes_bcd;
        tick_nxt = 1'b0;
        if (clear) begin
            pcnt_nxt = '0;
            min_nxt  = '0;
            bcd_nxt  = '0;
        end else if (run) begin
            if (pcnt >= term) begin
                pcnt_nxt = '0;
                if (minutes < MAX_M) begin
                    min_nxt  = minutes + 8'd1;
                    bcd_nxt  = bcd_inc;
                    tick_nxt = 1'b1;
                end
            end else begin
                pcnt_nxt = pcnt + PW'(1);
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pcnt        <= '0;
            minutes     <= '0;
            minutes_bcd <= '0;
            min_tick    <= 1'b0;
            saturated   <= 1'b0;
        end else begin
            pcnt        <= pcnt_nxt;
            minutes     <= min_nxt;
            minutes_bcd <= bcd_nxt;
            min_tick    <= tick_nxt;
            saturated   <= (min_nxt == MAX_M);
        end
    end

endmodule

// File: tb/tb_game_minute_timer.sv
// Directed bench for game_minute_timer with TICKS_PER_MIN=10, FAST_DIV=5, MAX_MIN=255.
module tb_game_minute_timer;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        clear = 1'b0;
    logic        run = 1'b0;
    logic        fast = 1'b0;
    logic [7:0]  minutes;
    logic [11:0] minutes_bcd;
    logic        min_tick;
    logic        saturated;

    int total = 0;
    int bad = 0;

    game_minute_timer #(
        .TICKS_PER_MIN(10),
        .FAST_DIV     (5),
        .MAX_MIN      (255)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .clear      (clear),
        .run        (run),
        .fast       (fast),
        .minutes    (minutes),
        .minutes_bcd(minutes_bcd),
        .min_tick   (min_tick),
        .saturated  (saturated)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        logic [11:0] r;
        r[11:8] = 4'(v / 100);
        r[7:4]  = 4'((v / 10) % 10);
        r[3:0]  = 4'(v % 10);
        return r;
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        run   = 1'b0;
        clear = 1'b0;
        fast  = 1'b0;
        step();
        Reset = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_min"}, 32'(minutes), 32'd0);
        check({tag, "_bcd"}, 32'(minutes_bcd), 32'd0);
        check({tag, "_tick"}, 32'(min_tick), 32'd0);
        check({tag, "_sat"}, 32'(saturated), 32'd0);
    endtask

    initial begin
        // 1: normal counting, ticks on cycles 10, 20, 30
        do_reset();
        check_zero("t1_reset");
        run = 1'b1;
        for (int i = 1; i <= 35; i++) begin
            step();
            check("t1_tick", 32'(min_tick), 32'(i % 10 == 0));
            check("t1_min", 32'(minutes), 32'(i / 10));
        end
        check("t1_bcd", 32'(minutes_bcd), 32'h003);

        // 2: pause keeps the partial minute
        do_reset();
        run = 1'b1;
        for (int i = 1; i <= 4; i++) step();
        run = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            step();
            check("t2_pause_tick", 32'(min_tick), 32'd0);
        end
        check("t2_pause_min", 32'(minutes), 32'd0);
        run = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step();
            check("t2_tick", 32'(min_tick), 32'(i == 6));
            check("t2_min", 32'(minutes), 32'(i == 6));
        end

        // 3: switching to fast with pcnt above the fast terminal
        do_reset();
        run = 1'b1;
        for (int i = 1; i <= 7; i++) step();
        check("t3_pre_min", 32'(minutes), 32'd0);
        fast = 1'b1;
        step();
        check("t3_roll_tick", 32'(min_tick), 32'd1);
        check("t3_roll_min", 32'(minutes), 32'd1);
        for (int i = 1; i <= 6; i++) begin
            step();
            check("t3_fast_tick", 32'(min_tick), 32'(i % 2 == 0));
            check("t3_fast_min", 32'(minutes), 32'(1 + i / 2));
        end

        // 4: decimal carries and saturation at 255
        do_reset();
        run  = 1'b1;
        fast = 1'b1;
        for (int i = 1; i <= 560; i++) begin
            int m;
            step();
            m = (i > 510) ? 255 : i / 2;
            check("t4_tick", 32'(min_tick), 32'((i % 2 == 0) && (i <= 510)));
            check("t4_min", 32'(minutes), 32'(m));
            check("t4_bcd", 32'(minutes_bcd), 32'(to_bcd(m)));
            check("t4_sat", 32'(saturated), 32'(m == 255));
            if (i == 198) check("t4_bcd99", 32'(minutes_bcd), 32'h099);
            if (i == 200) check("t4_bcd100", 32'(minutes_bcd), 32'h100);
        end
        check("t4_bcd255", 32'(minutes_bcd), 32'h255);

        // 5: synchronous clear mid-minute while running
        do_reset();
        run = 1'b1;
        for (int i = 1; i <= 373; i++) step();
        check("t5_pre_min", 32'(minutes), 32'd37);
        check("t5_pre_bcd", 32'(minutes_bcd), 32'h037);
        clear = 1'b1;
        step();
        check_zero("t5_clear");
        clear = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            step();
            check("t5_tick", 32'(min_tick), 32'(i == 10));
            check("t5_min", 32'(minutes), 32'(i >= 10));
        end

        // 6: asynchronous reset mid-minute
        do_reset();
        run = 1'b1;
        for (int i = 1; i <= 25; i++) step();
        check("t6_pre_min", 32'(minutes), 32'd2);
        #3 Reset = 1'b1;
        #1;
        check_zero("t6_async");
        @(posedge Clk);
        #3 Reset = 1'b0;
        for (int i = 1; i <= 11; i++) begin
            step();
            check("t6_tick", 32'(min_tick), 32'(i == 10));
            check("t6_min", 32'(minutes), 32'(i >= 10));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
